// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: datapath width, the canonical NOP, the fetch FSM
// encoding and the default reset PC.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_FLUSH
    } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO holding {pc, inst} pairs between imem and decode.
// flush_i empties it in one cycle and overrides any push in that cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; count_q alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem requests, buffers
// in-order responses and hands {inst, pc, pc+4} to decode; redirects drop stale words.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target_pc;
    logic [CNT_W-1:0]  in_flight_q, in_flight_d, drop_cnt_q, drop_cnt_d, fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              req_accept, fifo_push, fifo_pop;
    logic [2*XLEN-1:0] fifo_head;
    logic              unused_redirect_lsbs;

    assign target_pc            = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
    assign credit_used          = {1'b0, in_flight_q} + {1'b0, fifo_count};
    assign req_accept           = imem_req_valid_o && imem_req_ready_i;
    // A response is kept only if no stale words remain and no redirect lands this cycle.
    assign fifo_push            = imem_rsp_valid_i && !redirect_i && (drop_cnt_q == '0);
    assign fifo_pop             = inst_valid_o && inst_ready_i;

    always_comb begin
        in_flight_d = in_flight_q;
        if (req_accept && !imem_rsp_valid_i) begin
            in_flight_d = in_flight_q + CNT_W'(1);
        end else if (!req_accept && imem_rsp_valid_i) begin
            in_flight_d = in_flight_q - CNT_W'(1);
        end

        drop_cnt_d = drop_cnt_q;
        if (redirect_i) begin
            drop_cnt_d = in_flight_d;
        end else if (imem_rsp_valid_i && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end

        fetch_pc_d = fetch_pc_q;
        if (redirect_i) begin
            fetch_pc_d = target_pc;
        end else if (req_accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        // PC of the next response that will be kept: kept words are always sequential.
        rsp_pc_d = rsp_pc_q;
        if (redirect_i) begin
            rsp_pc_d = target_pc;
        end else if (fifo_push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            in_flight_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            in_flight_q <= in_flight_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_IDLE:  state_d = FETCH_RUN;
            FETCH_RUN:   if (redirect_i && (in_flight_d != '0)) state_d = FETCH_FLUSH;
            FETCH_FLUSH: if (drop_cnt_d == '0) state_d = FETCH_RUN;
            default:     state_d = FETCH_IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid_o = (state_q != FETCH_IDLE) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
        imem_req_addr_o  = fetch_pc_q;
        inst_valid_o     = (fifo_count != '0);
        inst_o           = INST_NOP;
        pc_o             = '0;
        if (inst_valid_o) begin
            inst_o = fifo_head[XLEN-1:0];
            pc_o   = fifo_head[2*XLEN-1:XLEN];
        end
        pc_plus4_o = pc_o + 32'd4;
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect_i),
        .push_i      (fifo_push),
        .push_data_i ({rsp_pc_q, imem_rsp_data_i}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(imem_rsp_valid_i && (in_flight_q == '0)));
        end
    end
endmodule
